// File: rtl/gp_delay_pkg.sv
// ============================================================================
// Module      : gp_delay_pkg
// Description : Shared state encoding and edge-mode constants for the delay counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gp_delay_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam logic [1:0] EDGE_RISE = 2'd0;
  localparam logic [1:0] EDGE_FALL = 2'd1;
  localparam logic [1:0] EDGE_BOTH = 2'd2;

endpackage

`default_nettype wire

// File: rtl/gp_edge_qual.sv
// ============================================================================
// Module      : gp_edge_qual
// Description : Registers IN and strobes when a transition matches the edge mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_edge_qual #(
  parameter logic [1:0] EDGE_MODE = 2'd0,
  parameter logic       INIT      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic qual_o
);
  import gp_delay_pkg::*;

  logic in_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_q <= INIT;
    end else begin
      in_q <= in_i;
    end
  end

  // Strobe is combinational so the edge is acted on by the clock that samples it.
  always_comb begin
    qual_o = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: qual_o = in_i & ~in_q;
      EDGE_FALL: qual_o = ~in_i & in_q;
      EDGE_BOTH: qual_o = in_i ^ in_q;
      default:   qual_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gp_delay_counter.sv
// ============================================================================
// Module      : gp_delay_counter
// Description : Retriggerable edge-to-level delay line with freeze (KEEP) input.
//               Optional glitch filter: define GP_DELAY_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gp_delay_counter #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned DELAY_COUNT = 10,
  parameter logic [1:0]  EDGE_MODE   = 2'd0,
  parameter logic        INIT        = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN,
  input  logic                   KEEP,
  output logic                   OUT,
  output logic                   POUT,
  output logic                   BUSY,
  output logic [COUNT_WIDTH-1:0] COUNT
);
  import gp_delay_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] c_LOAD = COUNT_WIDTH'(DELAY_COUNT);
  localparam logic [COUNT_WIDTH-1:0] c_ONE  = COUNT_WIDTH'(1);

  if (DELAY_COUNT == 0 || 64'(DELAY_COUNT) >= (64'd1 << COUNT_WIDTH)) begin : g_bad_delay
    $error("gp_delay_counter: DELAY_COUNT outside 1..2^COUNT_WIDTH-1");
  end
  if (EDGE_MODE > EDGE_BOTH) begin : g_bad_edge_mode
    $error("gp_delay_counter: EDGE_MODE must be 0, 1 or 2");
  end

  gp_delay_pkg::state_e   state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   target_q, target_d;
  logic                   out_q, out_d;
  logic                   pout_q, pout_d;
  logic                   w_qual;
  logic                   w_abort;

  gp_edge_qual #(
    .EDGE_MODE (EDGE_MODE),
    .INIT      (INIT)
  ) u_edge_qual (
    .clk_i  (CLK),
    .rst_i  (RST),
    .in_i   (IN),
    .qual_o (w_qual)
  );

`ifdef GP_DELAY_GLITCH_FILTER_EN
  assign w_abort = (IN == out_q);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= gp_delay_pkg::IDLE;
      count_q  <= '0;
      target_q <= INIT;
      out_q    <= INIT;
      pout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      out_q    <= out_d;
      pout_q   <= pout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    out_d    = out_q;
    pout_d   = 1'b0;
    case (state_q)
      gp_delay_pkg::IDLE: begin
        count_d = '0;
        if (w_qual) begin
          count_d  = c_LOAD;
          target_d = IN;
          state_d  = gp_delay_pkg::COUNT;
        end
      end
      gp_delay_pkg::COUNT: begin
        // Abort beats retrigger, which beats KEEP and the terminal-count update.
        if (w_abort) begin
          count_d = '0;
          state_d = gp_delay_pkg::IDLE;
        end else if (w_qual) begin
          count_d  = c_LOAD;
          target_d = IN;
        end else if (!KEEP) begin
          if (count_q == c_ONE) begin
            count_d = '0;
            out_d   = target_q;
            pout_d  = 1'b1;
            state_d = gp_delay_pkg::IDLE;
          end else begin
            count_d = count_q - c_ONE;
          end
        end
      end
      default: begin
        count_d = '0;
        state_d = gp_delay_pkg::IDLE;
      end
    endcase
  end

  assign OUT   = out_q;
  assign POUT  = pout_q;
  assign BUSY  = (state_q == gp_delay_pkg::COUNT);
  assign COUNT = count_q;

endmodule

`default_nettype wire

// File: tb/tb_gp_delay_counter.sv
// ============================================================================
// Module      : tb_gp_delay_counter
// Description : Scoreboard bench for gp_delay_counter (several configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gp_delay_counter;

  typedef struct packed {
    logic       out;
    logic       pout;
    logic       busy;
    logic [7:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_s = 1'b0;
  logic keep = 1'b0;

  logic out_a, pout_a, busy_a; logic [7:0] cnt_a;
  logic out_b, pout_b, busy_b; logic [7:0] cnt_b;
  logic out_d, pout_d, busy_d; logic [7:0] cnt_d;
  logic out_i, pout_i, busy_i; logic [7:0] cnt_i;
  obs_t obs_a, obs_b, obs_d, obs_i;

  assign obs_a = {out_a, pout_a, busy_a, cnt_a};
  assign obs_b = {out_b, pout_b, busy_b, cnt_b};
  assign obs_d = {out_d, pout_d, busy_d, cnt_d};
  assign obs_i = {out_i, pout_i, busy_i, cnt_i};

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gp_delay_counter u_dut (
    .CLK(clk), .RST(rst), .IN(in_s), .KEEP(keep),
    .OUT(out_a), .POUT(pout_a), .BUSY(busy_a), .COUNT(cnt_a)
  );

  gp_delay_counter #(.EDGE_MODE(2'd2)) u_both (
    .CLK(clk), .RST(rst), .IN(in_s), .KEEP(keep),
    .OUT(out_b), .POUT(pout_b), .BUSY(busy_b), .COUNT(cnt_b)
  );

  gp_delay_counter #(.DELAY_COUNT(1), .EDGE_MODE(2'd2)) u_d1 (
    .CLK(clk), .RST(rst), .IN(in_s), .KEEP(keep),
    .OUT(out_d), .POUT(pout_d), .BUSY(busy_d), .COUNT(cnt_d)
  );

  gp_delay_counter #(.INIT(1'b1)) u_i1 (
    .CLK(clk), .RST(rst), .IN(in_s), .KEEP(keep),
    .OUT(out_i), .POUT(pout_i), .BUSY(busy_i), .COUNT(cnt_i)
  );

  function automatic obs_t mk(logic o, logic p, logic b, logic [7:0] c);
    return {o, p, b, c};
  endfunction

  // Expected outputs eff un-frozen cycles after the detecting clock.
  function automatic obs_t exp_after(int eff, int d, logic tgt, logic prev);
    if (eff < d)  return {prev, 1'b0, 1'b1, 8'(d - eff)};
    if (eff == d) return {tgt, 1'b1, 1'b0, 8'd0};
    return {tgt, 1'b0, 1'b0, 8'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_s = 1'b0;
    keep = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    in_s = 1'b0;
    keep = 1'b0;
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0));
    e = exp_q.pop_front(); vectors++;
    if (obs_a !== e) begin
      miscompares++;
      $display("FAIL reset_default: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
    end
    e = exp_q.pop_front(); vectors++;
    if (obs_i !== e) begin
      miscompares++;
      $display("FAIL reset_init1: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", obs_i.out, obs_i.pout, obs_i.busy, obs_i.cnt, e.out, e.pout, e.busy, e.cnt);
    end
    tick();
    rst = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0));
    tick();
    e = exp_q.pop_front(); vectors++;
    if (obs_a !== e) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
    end
    e = exp_q.pop_front(); vectors++;
    if (obs_i !== e) begin
      miscompares++;
      $display("FAIL init1_fall_ignored: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", obs_i.out, obs_i.pout, obs_i.busy, obs_i.cnt, e.out, e.pout, e.busy, e.cnt);
    end
  endtask

  task automatic test_basic();
    obs_t e;
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back(exp_after(k, 10, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL basic cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
  endtask

  // KEEP is also high on the detecting clock, where it must have no effect.
  task automatic test_keep();
    obs_t e;
    int   eff;
    do_reset();
    in_s = 1'b1;
    keep = 1'b1;
    for (int k = 0; k < 16; k++) begin
      eff = (k <= 3) ? k : ((k <= 6) ? 3 : k - 3);
      exp_q.push_back(exp_after(eff, 10, 1'b1, 1'b0));
      tick();
      keep = (k >= 3 && k <= 5);
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL keep cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
    keep = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t e;
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(exp_after(k, 10, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL async_pre cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
    #3 rst = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs_a !== e) begin
      miscompares++;
      $display("FAIL async_assert: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(exp_after(k, 10, 1'b1, 1'b0));
      tick();
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL async_resume cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
  endtask

`ifdef GP_DELAY_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    obs_t e;
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back((k < 3) ? mk(1'b0, 1'b0, 1'b1, 8'(10 - k)) : mk(1'b0, 1'b0, 1'b0, 8'd0));
      tick();
      if (k == 2) begin
        in_s = 1'b0;
        keep = 1'b1;
      end
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL glitch cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
    keep = 1'b0;
  endtask
`else
  task automatic test_retrigger();
    obs_t e;
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back((k < 4) ? exp_after(k, 10, 1'b1, 1'b0) : exp_after(k - 4, 10, 1'b0, 1'b0));
      tick();
      if (k == 3) in_s = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if (obs_b !== e) begin
        miscompares++;
        $display("FAIL retrigger cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_b.out, obs_b.pout, obs_b.busy, obs_b.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
  endtask

  task automatic test_terminal_priority();
    obs_t e;
    obs_t plan [4];
    plan[0] = mk(1'b0, 1'b0, 1'b1, 8'd1);
    plan[1] = mk(1'b0, 1'b0, 1'b1, 8'd1);
    plan[2] = mk(1'b0, 1'b1, 1'b0, 8'd0);
    plan[3] = mk(1'b0, 1'b0, 1'b0, 8'd0);
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(plan[k]);
      tick();
      in_s = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if (obs_d !== e) begin
        miscompares++;
        $display("FAIL terminal cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_d.out, obs_d.pout, obs_d.busy, obs_d.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
  endtask

  // IN returns to OUT mid-count on a non-qualifying edge: delay must run out.
  task automatic test_no_abort();
    obs_t e;
    do_reset();
    in_s = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back(exp_after(k, 10, 1'b1, 1'b0));
      tick();
      if (k == 2) in_s = 1'b0;
      e = exp_q.pop_front(); vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL no_abort cyc%0d: got %b/%b/%b/%0d, expected %b/%b/%b/%0d", k, obs_a.out, obs_a.pout, obs_a.busy, obs_a.cnt, e.out, e.pout, e.busy, e.cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_keep();
`ifdef GP_DELAY_GLITCH_FILTER_EN
    test_glitch_filter();
`else
    test_retrigger();
    test_terminal_priority();
    test_no_abort();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
